// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared Memory.
// The slave modport is the arbiter's view. The master modport is the requesters' and Memory's view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic [DATA_W-1:0] mem_dataout;
    logic              mem_sigwr;
    logic              mem_sigon;

    logic              busy;
    logic              grant_id;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output ack0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, rdata1,
        output mem_addr, mem_datain, mem_sigwr, mem_sigon,
        input  mem_dataout,
        output busy, grant_id
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  ack0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, rdata1,
        input  mem_addr, mem_datain, mem_sigwr, mem_sigon,
        output mem_dataout,
        input  busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared 32x32 Memory.
// Each access takes exactly three cycles: IDLE (grant), ACCESS (memory enabled), DONE (ack).
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter bit          DEFAULT_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdin_q, mdin_d;
    logic              sigwr_q, sigwr_d;
    logic              sigon_q, sigon_d;
    logic              busy_q, busy_d;
    logic              winner;

    // State and every output are registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= ~DEFAULT_PRIO;
            grant_q  <= DEFAULT_PRIO;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            maddr_q  <= '0;
            mdin_q   <= '0;
            sigwr_q  <= 1'b0;
            sigon_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            maddr_q  <= maddr_d;
            mdin_q   <= mdin_d;
            sigwr_q  <= sigwr_d;
            sigon_q  <= sigon_d;
            busy_q   <= busy_d;
        end
    end

    // Next state and next output values; acks are single-cycle pulses and default low
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        maddr_d  = maddr_q;
        mdin_d   = mdin_q;
        sigwr_d  = sigwr_q;
        sigon_d  = sigon_q;
        busy_d   = busy_q;
        winner   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // A contested grant goes to the port that did not win last time
                    winner  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    maddr_d = winner ? bus.addr1  : bus.addr0;
                    mdin_d  = winner ? bus.wdata1 : bus.wdata0;
                    sigwr_d = winner ? bus.we1    : bus.we0;
                    sigon_d = 1'b1;
                    grant_d = winner;
                    last_d  = winner;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (grant_q) begin
                    rdata1_d = bus.mem_dataout;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = bus.mem_dataout;
                    ack0_d   = 1'b1;
                end
                sigon_d = 1'b0;
                sigwr_d = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_datain = mdin_q;
    assign bus.mem_sigwr  = sigwr_q;
    assign bus.mem_sigon  = sigon_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
endmodule
